// File: rtl/vga_regbank_scheduler.sv
// vga_regbank_scheduler: time-shares the single-port 16x8 time/chrono bank
// between the RTC/chrono controller and the per-frame VGA snapshot burst.
//
// RTC handshake: the requester raises rtc_req and holds rtc_we/rtc_addr/
// rtc_wdata stable. rtc_gnt pulses in the cycle the access drives the bank.
// rtc_done (with rtc_rdata) pulses two cycles later. rtc_req is ignored from
// the grant edge through the rtc_done cycle, and the requester drops it in
// the cycle after rtc_done.
module vga_regbank_scheduler #(
   parameter int ADDR_W        = 4,
   parameter int DATA_W        = 8,
   parameter int FIRST_ADDR    = 1,
   parameter int NUM_REGS      = 12,
   parameter int WR_STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              VSync,
   input  logic              rtc_req,
   input  logic              rtc_we,
   input  logic [ADDR_W-1:0] rtc_addr,
   input  logic [DATA_W-1:0] rtc_wdata,
   output logic              rtc_gnt,
   output logic              rtc_done,
   output logic [DATA_W-1:0] rtc_rdata,
   output logic [ADDR_W-1:0] bank_addr,
   output logic              bank_we,
   output logic [DATA_W-1:0] bank_wdata,
   input  logic [DATA_W-1:0] bank_rdata,
   output logic              snap_valid,
   output logic [ADDR_W-1:0] snap_addr,
   output logic [DATA_W-1:0] snap_data,
   output logic              frame_done,
   output logic              frame_torn,
   output logic              dbg_state
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   localparam int WAIT_W = $clog2(WR_STARVE_MAX + 2);
   localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(FIRST_ADDR);
   localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(FIRST_ADDR + NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WR_STARVE_MAX);
   localparam logic [WAIT_W-1:0] ONE_W    = WAIT_W'(1);

   logic [0:0]        state_q, state_d;
   logic              vs_q;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              busy_q, busy_d;
   logic              torn_q, torn_d;
   logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
   logic              bank_we_q, bank_we_d;
   logic [DATA_W-1:0] bank_wdata_q, bank_wdata_d;
   logic              rtc_gnt_q, rtc_gnt_d;
   logic              rtc_p1_q;
   logic              rtc_done_q;
   logic [DATA_W-1:0] rtc_rdata_q, rtc_rdata_d;
   logic              vga_v0_q, vga_v0_d;
   logic              vga_last0_q, vga_last0_d;
   logic              vga_v1_q, vga_last1_q;
   logic [ADDR_W-1:0] vga_addr1_q;
   logic              snap_valid_q, frame_done_q;
   logic [ADDR_W-1:0] snap_addr_q, snap_addr_d;
   logic [DATA_W-1:0] snap_data_q, snap_data_d;

   logic fall, rtc_pend, grant_rtc, grant_vga;

   // Arbitration of the single bank slot and burst sequencing.
   always_comb begin
      fall      = vs_q & ~VSync;
      rtc_pend  = rtc_req & ~busy_q;
      grant_rtc = 1'b0;
      grant_vga = 1'b0;
      state_d   = state_q;
      ptr_d     = ptr_q;
      wait_d    = wait_q;
      // busy drops only after the rtc_done cycle so a still-held request is not re-granted
      busy_d    = rtc_done_q ? 1'b0 : busy_q;
      torn_d    = torn_q;
      vga_last0_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            grant_rtc = rtc_pend;
            if (fall) begin
               state_d = ST_BURST;
               ptr_d   = FIRST_A;
               wait_d  = '0;
               torn_d  = 1'b0;
            end
         end
         default: begin
            if (rtc_pend && (wait_q == WAIT_MAX)) begin
               grant_rtc = 1'b1;
               wait_d    = '0;
               // only a write to an already-fetched address breaks coherence
               if (rtc_we && (rtc_addr >= FIRST_A) && (rtc_addr < ptr_q)) begin
                  torn_d = 1'b1;
               end
            end else begin
               grant_vga   = 1'b1;
               ptr_d       = ptr_q + ONE_A;
               wait_d      = rtc_pend ? (wait_q + ONE_W) : '0;
               vga_last0_d = (ptr_q == LAST_A);
               if (ptr_q == LAST_A) begin
                  state_d = ST_IDLE;
               end
            end
         end
      endcase
      bank_addr_d  = '0;
      bank_we_d    = 1'b0;
      bank_wdata_d = '0;
      rtc_gnt_d    = 1'b0;
      vga_v0_d     = 1'b0;
      if (grant_rtc) begin
         bank_addr_d  = rtc_addr;
         bank_we_d    = rtc_we;
         bank_wdata_d = rtc_wdata;
         rtc_gnt_d    = 1'b1;
         busy_d       = 1'b1;
      end else if (grant_vga) begin
         bank_addr_d = ptr_q;
         vga_v0_d    = 1'b1;
      end
   end

   // Capture of bank read data for the RTC and snapshot return paths.
   always_comb begin
      rtc_rdata_d = rtc_p1_q ? bank_rdata : rtc_rdata_q;
      snap_addr_d = vga_v1_q ? vga_addr1_q : snap_addr_q;
      snap_data_d = vga_v1_q ? bank_rdata : snap_data_q;
   end

   // State, slot and return-pipeline registers.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q      <= ST_IDLE;
         vs_q         <= 1'b1;
         ptr_q        <= '0;
         wait_q       <= '0;
         busy_q       <= 1'b0;
         torn_q       <= 1'b0;
         bank_addr_q  <= '0;
         bank_we_q    <= 1'b0;
         bank_wdata_q <= '0;
         rtc_gnt_q    <= 1'b0;
         rtc_p1_q     <= 1'b0;
         rtc_done_q   <= 1'b0;
         rtc_rdata_q  <= '0;
         vga_v0_q     <= 1'b0;
         vga_last0_q  <= 1'b0;
         vga_v1_q     <= 1'b0;
         vga_last1_q  <= 1'b0;
         vga_addr1_q  <= '0;
         snap_valid_q <= 1'b0;
         snap_addr_q  <= '0;
         snap_data_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vs_q         <= VSync;
         ptr_q        <= ptr_d;
         wait_q       <= wait_d;
         busy_q       <= busy_d;
         torn_q       <= torn_d;
         bank_addr_q  <= bank_addr_d;
         bank_we_q    <= bank_we_d;
         bank_wdata_q <= bank_wdata_d;
         rtc_gnt_q    <= rtc_gnt_d;
         rtc_p1_q     <= rtc_gnt_q;
         rtc_done_q   <= rtc_p1_q;
         rtc_rdata_q  <= rtc_rdata_d;
         vga_v0_q     <= vga_v0_d;
         vga_last0_q  <= vga_last0_d;
         vga_v1_q     <= vga_v0_q;
         vga_last1_q  <= vga_v0_q & vga_last0_q;
         vga_addr1_q  <= bank_addr_q;
         snap_valid_q <= vga_v1_q;
         snap_addr_q  <= snap_addr_d;
         snap_data_q  <= snap_data_d;
         frame_done_q <= vga_v1_q & vga_last1_q;
      end
   end

   assign rtc_gnt    = rtc_gnt_q;
   assign rtc_done   = rtc_done_q;
   assign rtc_rdata  = rtc_rdata_q;
   assign bank_addr  = bank_addr_q;
   assign bank_we    = bank_we_q;
   assign bank_wdata = bank_wdata_q;
   assign snap_valid = snap_valid_q;
   assign snap_addr  = snap_addr_q;
   assign snap_data  = snap_data_q;
   assign frame_done = frame_done_q;
   assign frame_torn = torn_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_vga_regbank_scheduler.sv
// Directed bench for vga_regbank_scheduler with a registered 16x8 bank model.
module tb_vga_regbank_scheduler;

   logic       clk = 1'b0;
   logic       RESET;
   logic       VSync;
   logic       rtc_req;
   logic       rtc_we;
   logic [3:0] rtc_addr;
   logic [7:0] rtc_wdata;
   logic       rtc_gnt, rtc_done;
   logic [7:0] rtc_rdata;
   logic [3:0] bank_addr;
   logic       bank_we;
   logic [7:0] bank_wdata;
   logic [7:0] bank_rdata;
   logic       snap_valid;
   logic [3:0] snap_addr;
   logic [7:0] snap_data;
   logic       frame_done, frame_torn, dbg_state;

   logic       preload;
   logic [7:0] mem [16];
   logic [7:0] shadow [16];
   int         cyc = 0;

   logic [3:0] got_a[$];
   logic [7:0] got_d[$];
   logic [3:0] slot_a[$];
   logic       slot_we[$];
   int         slot_c[$];
   int         fd_cnt;
   logic [3:0] fd_addr;
   logic       fd_sv;
   logic [7:0] exp_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   vga_regbank_scheduler dut (
      .CLK(clk), .RESET(RESET), .VSync(VSync),
      .rtc_req(rtc_req), .rtc_we(rtc_we), .rtc_addr(rtc_addr), .rtc_wdata(rtc_wdata),
      .rtc_gnt(rtc_gnt), .rtc_done(rtc_done), .rtc_rdata(rtc_rdata),
      .bank_addr(bank_addr), .bank_we(bank_we), .bank_wdata(bank_wdata),
      .bank_rdata(bank_rdata),
      .snap_valid(snap_valid), .snap_addr(snap_addr), .snap_data(snap_data),
      .frame_done(frame_done), .frame_torn(frame_torn), .dbg_state(dbg_state)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bank model: registered read, data valid the cycle after the address.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
      end else if (bank_we) begin
         mem[bank_addr] <= bank_wdata;
      end
      bank_rdata <= mem[bank_addr];
   end

   // Monitor: logs bank slots, snapshot words and frame_done away from the edge.
   always @(negedge clk) begin
      if (bank_we || (bank_addr != 4'd0)) begin
         slot_a.push_back(bank_addr);
         slot_we.push_back(bank_we);
         slot_c.push_back(cyc);
      end
      if (snap_valid) begin
         got_a.push_back(snap_addr);
         got_d.push_back(snap_data);
      end
      if (frame_done) begin
         fd_cnt  = fd_cnt + 1;
         fd_addr = snap_addr;
         fd_sv   = snap_valid;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      got_a.delete(); got_d.delete();
      slot_a.delete(); slot_we.delete(); slot_c.delete();
      fd_cnt = 0; fd_addr = 4'd0; fd_sv = 1'b0;
   endtask

   function automatic logic [63:0] all_outs();
      return {26'd0, rtc_gnt, rtc_done, rtc_rdata, bank_addr, bank_we, bank_wdata,
              snap_valid, snap_addr, snap_data, frame_done, frame_torn};
   endfunction

   // One RTC access; records grant/done cycles and the bank slot at grant.
   task automatic rtc_xfer(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                           output int req_c, output int gnt_c, output int done_c,
                           output int gnt_n, output logic [12:0] gnt_bank,
                           output logic [7:0] rd);
      bit done = 0;
      gnt_n = 0; gnt_c = -1; done_c = -1; gnt_bank = '0; rd = '0;
      rtc_we = we; rtc_addr = addr; rtc_wdata = wd; rtc_req = 1'b1;
      req_c = cyc;
      for (int i = 0; i < 30 && !done; i++) begin
         step();
         if (rtc_gnt) begin
            gnt_n++; gnt_c = cyc; gnt_bank = {bank_we, bank_addr, bank_wdata};
         end
         if (rtc_done) begin
            done = 1; done_c = cyc; rd = rtc_rdata;
         end
      end
      if (!done) chk("rtc_timeout", 64'd0, 64'd1);
      step();
      if (rtc_gnt) gnt_n++;
      rtc_req = 1'b0;
   endtask

   task automatic check_snaps(input string tag);
      exp_q.delete();
      for (int a = 1; a <= 12; a++) exp_q.push_back(shadow[a]);
      chk({tag, "_count"}, 64'(got_d.size()), 64'd12);
      for (int i = 0; i < 12 && i < got_d.size(); i++) begin
         chk({tag, "_addr"}, 64'(got_a[i]), 64'(i + 1));
         chk({tag, "_data"}, 64'(got_d[i]), 64'(exp_q.pop_front()));
      end
      chk({tag, "_fd_cnt"}, 64'(fd_cnt), 64'd1);
      chk({tag, "_fd_addr"}, 64'({fd_sv, fd_addr}), 64'({1'b1, 4'd12}));
   endtask

   int         rq, gc, dc, gn;
   logic [12:0] gb;
   logic [7:0]  rd;

   initial begin
      for (int i = 0; i < 16; i++) shadow[i] = 8'(i * 17);
      clear_logs();
      // Reset with a pending request and a VSync fall.
      RESET = 1'b0; preload = 1'b1; VSync = 1'b1;
      rtc_req = 1'b1; rtc_we = 1'b1; rtc_addr = 4'd3; rtc_wdata = 8'hAA;
      step();
      chk("rst_outs0", all_outs(), 64'd0);
      VSync = 1'b0;
      step();
      chk("rst_outs1", all_outs(), 64'd0);
      step();
      chk("rst_outs2", all_outs(), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'd0);
      rtc_req = 1'b0; VSync = 1'b1; RESET = 1'b1; preload = 1'b0;
      clear_logs();
      for (int i = 0; i < 4; i++) step();
      chk("rst_no_slots", 64'(slot_a.size()), 64'd0);
      chk("rst_no_snaps", 64'(got_d.size()), 64'd0);

      // Clean burst.
      clear_logs();
      VSync = 1'b0;
      for (int i = 0; i < 20; i++) step();
      VSync = 1'b1;
      chk("clean_slots", 64'(slot_a.size()), 64'd12);
      for (int i = 0; i < 12 && i < slot_a.size(); i++) begin
         chk("clean_slot", 64'({slot_we[i], slot_a[i]}), 64'({1'b0, 4'(i + 1)}));
         chk("clean_slot_cyc", 64'(slot_c[i] - slot_c[0]), 64'(i));
      end
      check_snaps("clean");
      chk("clean_torn", 64'(frame_torn), 64'd0);
      step(); step();

      // RTC write then read in idle.
      clear_logs();
      rtc_xfer(1'b1, 4'd5, 8'h37, rq, gc, dc, gn, gb, rd);
      chk("idle_wr_lat", 64'(gc - rq), 64'd1);
      chk("idle_wr_bank", 64'(gb), 64'({1'b1, 4'd5, 8'h37}));
      chk("idle_wr_done", 64'(dc - gc), 64'd2);
      chk("idle_wr_gnt_n", 64'(gn), 64'd1);
      shadow[5] = 8'h37;
      rtc_xfer(1'b0, 4'd5, 8'h00, rq, gc, dc, gn, gb, rd);
      chk("idle_rd_bank", 64'(gb[12:8]), 64'({1'b0, 4'd5}));
      chk("idle_rd_done", 64'(dc - gc), 64'd2);
      chk("idle_rd_data", 64'(rd), 64'h37);
      step(); step();

      // Starvation bound: write to already-fetched address 2 tears the frame.
      clear_logs();
      VSync = 1'b0;
      step();
      rtc_xfer(1'b1, 4'd2, 8'h5A, rq, gc, dc, gn, gb, rd);
      for (int i = 0; i < 14; i++) step();
      VSync = 1'b1;
      chk("starve_lat", 64'(gc - rq), 64'd5);
      chk("starve_gnt_n", 64'(gn), 64'd1);
      chk("starve_slots", 64'(slot_a.size()), 64'd13);
      for (int i = 0; i < 13 && i < slot_a.size(); i++) begin
         chk("starve_slot",
             64'({slot_we[i], slot_a[i]}),
             (i < 4) ? 64'({1'b0, 4'(i + 1)}) :
             (i == 4) ? 64'({1'b1, 4'd2}) : 64'({1'b0, 4'(i)}));
      end
      if (slot_c.size() == 13) chk("starve_span", 64'(slot_c[12] - slot_c[0]), 64'd12);
      check_snaps("starve");
      chk("starve_torn", 64'(frame_torn), 64'd1);
      shadow[2] = 8'h5A;
      step(); step();

      // Forward write: address 11 not yet fetched, snapshot sees new value.
      clear_logs();
      VSync = 1'b0;
      step();
      rtc_xfer(1'b1, 4'd11, 8'h59, rq, gc, dc, gn, gb, rd);
      for (int i = 0; i < 14; i++) step();
      VSync = 1'b1;
      shadow[11] = 8'h59;
      chk("fwd_lat", 64'(gc - rq), 64'd5);
      check_snaps("fwd");
      chk("fwd_torn", 64'(frame_torn), 64'd0);
      step(); step();

      // Reset after six reads aborts the burst.
      clear_logs();
      VSync = 1'b0;
      step();
      for (int i = 0; i < 6; i++) step();
      RESET = 1'b0; VSync = 1'b1;
      step();
      chk("mid_rst_outs", all_outs(), 64'd0);
      RESET = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("mid_rst_slots", 64'(slot_a.size()), 64'd6);
      chk("mid_rst_snaps", 64'(got_d.size()), 64'd4);
      chk("mid_rst_fd", 64'(fd_cnt), 64'd0);
      clear_logs();
      VSync = 1'b0;
      for (int i = 0; i < 20; i++) step();
      VSync = 1'b1;
      check_snaps("restart");
      chk("restart_torn", 64'(frame_torn), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
